// File: rtl/enigma_pkg.sv
// Shared Enigma constants, rotor indices, stepper state encoding
// and the mod-26 increment used by stepper and rotor offset adders.
package enigma_pkg;

  localparam int NUM_ROTORS = 3;
  localparam int LETTER_W   = 5;
  localparam int ALPHABET   = 26;

  localparam logic [1:0] R_RIGHT = 2'd0;
  localparam logic [1:0] R_MID   = 2'd1;
  localparam logic [1:0] R_LEFT  = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EVAL   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  typedef logic [LETTER_W-1:0] letter_t;

  localparam letter_t LAST_LETTER = letter_t'(ALPHABET - 1);

  // Wraps at the alphabet size, not at the 5-bit boundary.
  function automatic letter_t inc_mod26(letter_t x);
    return (x >= LAST_LETTER) ? '0 : x + letter_t'(1);
  endfunction

endpackage

// File: rtl/enigma_rotor_stepper_if.sv
// Control/status bundle between the Enigma core and the rotor stepper.
// master = core side, slave = stepper side.
interface enigma_rotor_stepper_if;
  import enigma_pkg::*;

  logic          load_valid;
  logic [1:0]    load_sel;
  letter_t       load_pos;
  letter_t       notch_r;
  letter_t       notch_m;
  logic          step_req;
  logic [14:0]   pos_out;
  logic          busy;
  logic          step_done;
  logic          load_err;

  modport master (
    output load_valid, load_sel, load_pos,
    output notch_r, notch_m, step_req,
    input  pos_out, busy, step_done, load_err
  );

  modport slave (
    input  load_valid, load_sel, load_pos,
    input  notch_r, notch_m, step_req,
    output pos_out, busy, step_done, load_err
  );

endinterface

// File: rtl/enigma_pos_reg.sv
// One rotor position: sync reset, load, and increment mod 26.
// Load has priority over increment.
module enigma_pos_reg
  import enigma_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load_en_i,
  input  letter_t load_val_i,
  input  logic    inc_en_i,
  output letter_t pos_o
);

  letter_t pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (load_en_i)
      pos_d = load_val_i;
    else if (inc_en_i)
      pos_d = inc_mod26(pos_q);
  end

  always_ff @(posedge clk) begin
    if (rst)
      pos_q <= '0;
    else
      pos_q <= pos_d;
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/enigma_rotor_stepper.sv
// Rotor position register and keypress stepping controller,
// including the middle-rotor double-step.
module enigma_rotor_stepper
  import enigma_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  enigma_rotor_stepper_if.slave   bus
);

  logic [1:0] state_q, state_d;
  logic       load_err_q, load_err_d;

  letter_t    pos [NUM_ROTORS];
  logic       ld  [NUM_ROTORS];
  logic       inc [NUM_ROTORS];

  logic is_idle, is_eval, is_commit;
  logic load_take, load_range_ok;
  logic load_ok, load_bad, step_go;
  logic at_r, at_m;

  assign is_idle   = (state_q == ST_IDLE);
  assign is_eval   = (state_q == ST_EVAL);
  assign is_commit = (state_q == ST_COMMIT);

  assign load_take     = is_idle & bus.load_valid
                       & (bus.load_sel != 2'd3);
  assign load_range_ok = (bus.load_pos <= LAST_LETTER);
  assign load_ok       = load_take & load_range_ok;
  assign load_bad      = load_take & ~load_range_ok;
  assign step_go       = is_idle & bus.step_req
                       & ~bus.load_valid;

  // Notch flags are taken from pre-step positions; the
  // new positions land on the EVAL->COMMIT edge so they
  // are visible together with step_done.
  assign at_r = (pos[R_RIGHT] == bus.notch_r);
  assign at_m = (pos[R_MID]   == bus.notch_m);

  always_comb begin
    inc[R_RIGHT] = is_eval;
    inc[R_MID]   = is_eval & (at_r | at_m);
    inc[R_LEFT]  = is_eval & at_m;
  end

  always_comb begin
    ld[R_RIGHT] = load_ok & (bus.load_sel == R_RIGHT);
    ld[R_MID]   = load_ok & (bus.load_sel == R_MID);
    ld[R_LEFT]  = load_ok & (bus.load_sel == R_LEFT);
  end

  for (genvar i = 0; i < NUM_ROTORS; i++) begin : g_rotor
    enigma_pos_reg u_pos (
      .clk        (clk),
      .rst        (rst),
      .load_en_i  (ld[i]),
      .load_val_i (bus.load_pos),
      .inc_en_i   (inc[i]),
      .pos_o      (pos[i])
    );
  end

  always_comb begin
    state_d = ST_IDLE;
    unique case (1'b1)
      is_idle:   state_d = step_go ? ST_EVAL : ST_IDLE;
      is_eval:   state_d = ST_COMMIT;
      is_commit: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign load_err_d = load_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.pos_out   = {pos[R_LEFT], pos[R_MID], pos[R_RIGHT]};
  assign bus.busy      = ~is_idle;
  assign bus.step_done = is_commit;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_enigma_rotor_stepper.sv
// Directed-vector bench for the Enigma rotor stepper.
module tb_enigma_rotor_stepper;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   chk_cnt;

  enigma_rotor_stepper_if bus ();

  enigma_rotor_stepper dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] pk(int l, int m, int r);
    logic [4:0] lv, mv, rv;
    lv = 5'(l);
    mv = 5'(m);
    rv = 5'(r);
    return {lv, mv, rv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(int sel, int p);
    bus.load_valid = 1'b1;
    bus.load_sel   = 2'(sel);
    bus.load_pos   = 5'(p);
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic do_step();
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    chk_cnt++;
    if ({bus.pos_out, bus.busy, bus.step_done, bus.load_err}
        !== {15'd0, 3'b000})
      $display("FAIL reset_state got pos=%h b=%b d=%b e=%b exp 0",
               bus.pos_out, bus.busy, bus.step_done, bus.load_err);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_first_step();
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    chk_cnt++;
    if ({bus.busy, bus.step_done, bus.pos_out} !== {2'b10, pk(0,0,0)})
      $display("FAIL first_eval got b=%b d=%b pos=%h exp b=1 d=0 pos=0",
               bus.busy, bus.step_done, bus.pos_out);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({bus.busy, bus.step_done, bus.pos_out} !== {2'b11, pk(0,0,1)})
      $display("FAIL first_commit got b=%b d=%b pos=%h exp b=1 d=1 pos=%h",
               bus.busy, bus.step_done, bus.pos_out, pk(0,0,1));
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({bus.busy, bus.step_done} !== 2'b00)
      $display("FAIL first_idle got b=%b d=%b exp 00",
               bus.busy, bus.step_done);
    else pass_cnt++;
  endtask

  task automatic test_right_wrap();
    bus.notch_r = 5'd25;
    bus.notch_m = 5'd31;
    do_load(0, 25);
    chk_cnt++;
    if (bus.pos_out !== pk(0,0,25))
      $display("FAIL load_right got %h exp %h", bus.pos_out, pk(0,0,25));
    else pass_cnt++;
    do_step();
    chk_cnt++;
    if (bus.pos_out !== pk(0,1,0))
      $display("FAIL right_wrap got %h exp %h", bus.pos_out, pk(0,1,0));
    else pass_cnt++;
  endtask

  task automatic test_double_step();
    bus.notch_r = 5'd4;
    bus.notch_m = 5'd4;
    do_load(2, 0);
    do_load(1, 3);
    do_load(0, 4);
    do_step();
    chk_cnt++;
    if (bus.pos_out !== pk(0,4,5))
      $display("FAIL dstep_1 got %h exp %h", bus.pos_out, pk(0,4,5));
    else pass_cnt++;
    tick();
    do_step();
    chk_cnt++;
    if (bus.pos_out !== pk(1,5,6))
      $display("FAIL dstep_2 got %h exp %h", bus.pos_out, pk(1,5,6));
    else pass_cnt++;
    tick();
  endtask

  task automatic test_load_err();
    do_load(1, 27);
    chk_cnt++;
    if ({bus.load_err, bus.pos_out} !== {1'b1, pk(1,5,6)})
      $display("FAIL load_err got e=%b pos=%h exp e=1 pos=%h",
               bus.load_err, bus.pos_out, pk(1,5,6));
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus.load_err !== 1'b0)
      $display("FAIL load_err_pulse got %b exp 0", bus.load_err);
    else pass_cnt++;
    do_load(3, 10);
    chk_cnt++;
    if ({bus.load_err, bus.pos_out} !== {1'b0, pk(1,5,6)})
      $display("FAIL load_sel3 got e=%b pos=%h exp e=0 pos=%h",
               bus.load_err, bus.pos_out, pk(1,5,6));
    else pass_cnt++;
  endtask

  task automatic test_load_vs_step();
    int dones;
    dones = 0;
    bus.step_req = 1'b1;
    do_load(0, 10);
    bus.step_req = 1'b0;
    chk_cnt++;
    if ({bus.busy, bus.pos_out} !== {1'b0, pk(1,5,10)})
      $display("FAIL load_wins got b=%b pos=%h exp b=0 pos=%h",
               bus.busy, bus.pos_out, pk(1,5,10));
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (bus.step_done) dones++;
      tick();
    end
    chk_cnt++;
    if (dones !== 0)
      $display("FAIL load_wins_done got %0d exp 0", dones);
    else pass_cnt++;
  endtask

  task automatic test_load_busy();
    bus.step_req = 1'b1;
    tick();
    bus.step_req   = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_sel   = 2'd2;
    bus.load_pos   = 5'd30;
    tick();
    bus.load_valid = 1'b0;
    chk_cnt++;
    if ({bus.load_err, bus.step_done, bus.pos_out}
        !== {2'b01, pk(1,5,11)})
      $display("FAIL load_busy got e=%b d=%b pos=%h exp e=0 d=1 pos=%h",
               bus.load_err, bus.step_done, bus.pos_out, pk(1,5,11));
    else pass_cnt++;
    tick();
  endtask

  task automatic test_throughput();
    int dones;
    dones = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.step_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.step_done) dones++;
    end
    bus.step_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.step_done) dones++;
    end
    chk_cnt++;
    if (dones !== 3)
      $display("FAIL thru_dones got %0d exp 3", dones);
    else pass_cnt++;
    chk_cnt++;
    if (bus.pos_out !== pk(0,0,3))
      $display("FAIL thru_pos got %h exp %h", bus.pos_out, pk(0,0,3));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_step();
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    tick();
    chk_cnt++;
    if ({bus.step_done, bus.pos_out} !== {1'b1, pk(0,0,4)})
      $display("FAIL pre_rst_commit got d=%b pos=%h exp d=1 pos=%h",
               bus.step_done, bus.pos_out, pk(0,0,4));
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cnt++;
    if ({bus.pos_out, bus.busy, bus.step_done} !== {15'd0, 2'b00})
      $display("FAIL rst_mid got pos=%h b=%b d=%b exp 0",
               bus.pos_out, bus.busy, bus.step_done);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({bus.busy, bus.step_done} !== 2'b00)
      $display("FAIL rst_mid_after got b=%b d=%b exp 00",
               bus.busy, bus.step_done);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt       = 0;
    chk_cnt        = 0;
    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_sel   = 2'd0;
    bus.load_pos   = 5'd0;
    bus.notch_r    = 5'd31;
    bus.notch_m    = 5'd31;
    bus.step_req   = 1'b0;
    test_reset();
    test_first_step();
    test_right_wrap();
    test_double_step();
    test_load_err();
    test_load_vs_step();
    test_load_busy();
    test_throughput();
    test_reset_mid_step();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
